// File: rtl/md_phase_sequencer_pkg.sv
// MD_pkg: shared types and defaults for the MD node phase sequencer.
//   md_phase_t          - FSM state encoding, also exported on o_phase
//   DEFAULT_CNT_WIDTH   - default width of the beat counters and beat counts
//   DEFAULT_ITER_WIDTH  - default width of the iteration count and counter
package MD_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INIT       = 3'd1,
        STEP_START = 3'd2,
        STEP_WAIT  = 3'd3,
        DUMP       = 3'd4,
        DONE       = 3'd5
    } md_phase_t;

    localparam int DEFAULT_CNT_WIDTH  = 16;
    localparam int DEFAULT_ITER_WIDTH = 16;

endpackage

// File: rtl/md_phase_sequencer_sat_beat_counter.sv
// sat_beat_counter: saturating up-counter with synchronous clear and a
// look-ahead compare against a target.
//   clk, rst    - clock, synchronous active-high reset
//   clr         - clear the count to zero (wins over inc)
//   inc         - count one event this cycle
//   target      - value compared against the next count
//   count       - current count
//   next_match  - high when the value the count takes next equals target
module sat_beat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic             next_match
);

    logic [WIDTH-1:0] count_next;

    // Sticks at all-ones instead of wrapping back to zero.
    assign count_next = (inc && (count != {WIDTH{1'b1}})) ? count + WIDTH'(1) : count;
    assign next_match = (count_next == target);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/md_phase_sequencer.sv
// md_phase_sequencer: run-phase controller for one MD node kernel.
// Sequences position init (host + network), N force/motion iterations
// handshaked with compute, then force dump to host.
//   clk, rst                  - clock, synchronous active-high reset
//   i_start / i_abort         - run request (IDLE only) / return to IDLE
//   i_node_ID, i_num_*        - run configuration, latched at start
//   i_h2k_tvalid/tlast        - host stream monitor (end of host data)
//   i_k2pc_tvalid             - beat written to the position caches
//   i_k2h_tvalid              - beat forwarded to host
//   i_step_done               - compute finished an iteration
//   o_init_start/o_dump_start - dispatcher enables
//   o_init_ID                 - latched node ID
//   o_step_start              - one-cycle iteration start pulse
//   o_phase, o_iter_cnt       - current state, completed iterations
//   o_busy, o_done            - not idle, one-cycle completion pulse
module md_phase_sequencer
    import MD_pkg::*;
#(
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter int ITER_WIDTH = DEFAULT_ITER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [15:0]           i_node_ID,
    input  logic [CNT_WIDTH-1:0]  i_num_pos_beats,
    input  logic [ITER_WIDTH-1:0] i_num_iters,
    input  logic [CNT_WIDTH-1:0]  i_num_dump_beats,
    input  logic                  i_h2k_tvalid,
    input  logic                  i_h2k_tlast,
    input  logic                  i_k2pc_tvalid,
    input  logic                  i_k2h_tvalid,
    input  logic                  i_step_done,
    output logic                  o_init_start,
    output logic                  o_dump_start,
    output logic [15:0]           o_init_ID,
    output logic                  o_step_start,
    output logic [2:0]            o_phase,
    output logic [ITER_WIDTH-1:0] o_iter_cnt,
    output logic                  o_busy,
    output logic                  o_done
);

    md_phase_t             state;
    logic [CNT_WIDTH-1:0]  num_pos;
    logic [ITER_WIDTH-1:0] num_iters;
    logic [CNT_WIDTH-1:0]  num_dump;
    logic                  host_fin;

    logic [CNT_WIDTH-1:0]  pos_cnt;
    logic [CNT_WIDTH-1:0]  dump_cnt;
    logic                  pos_match, iter_match, dump_match;
    logic                  cnt_clr, pos_inc, iter_inc, dump_inc;
    logic                  host_last, init_exit;

    // Counting only happens in the owning state and stops once the count
    // has reached its target, so late strobes cannot overshoot the exit
    // compare. An abort freezes all counters.
    assign cnt_clr   = (state == IDLE) && i_start && !i_abort;
    assign pos_inc   = (state == INIT) && i_k2pc_tvalid && !i_abort && (pos_cnt != num_pos);
    assign iter_inc  = (state == STEP_WAIT) && i_step_done && !i_abort && (o_iter_cnt != num_iters);
    assign dump_inc  = (state == DUMP) && i_k2h_tvalid && !i_abort && (dump_cnt != num_dump);

    assign host_last = i_h2k_tvalid && i_h2k_tlast;
    assign init_exit = (host_fin || host_last) && pos_match;

    sat_beat_counter #(.WIDTH(CNT_WIDTH)) u_pos_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(pos_inc),
        .target(num_pos), .count(pos_cnt), .next_match(pos_match)
    );

    sat_beat_counter #(.WIDTH(ITER_WIDTH)) u_iter_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(iter_inc),
        .target(num_iters), .count(o_iter_cnt), .next_match(iter_match)
    );

    sat_beat_counter #(.WIDTH(CNT_WIDTH)) u_dump_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(dump_inc),
        .target(num_dump), .count(dump_cnt), .next_match(dump_match)
    );

    assign o_phase = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            num_pos      <= '0;
            num_iters    <= '0;
            num_dump     <= '0;
            host_fin     <= 1'b0;
            o_init_ID    <= '0;
            o_init_start <= 1'b0;
            o_dump_start <= 1'b0;
            o_step_start <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else if (i_abort) begin
            // Config, host_fin and counters are deliberately kept.
            state        <= IDLE;
            o_init_start <= 1'b0;
            o_dump_start <= 1'b0;
            o_step_start <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        num_pos      <= i_num_pos_beats;
                        num_iters    <= i_num_iters;
                        num_dump     <= i_num_dump_beats;
                        o_init_ID    <= i_node_ID;
                        host_fin     <= 1'b0;
                        state        <= INIT;
                        o_init_start <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                INIT: begin
                    if (host_last) begin
                        host_fin <= 1'b1;
                    end
                    if (init_exit) begin
                        o_init_start <= 1'b0;
                        if (num_iters != '0) begin
                            state        <= STEP_START;
                            o_step_start <= 1'b1;
                        end else if (num_dump != '0) begin
                            state        <= DUMP;
                            o_dump_start <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                STEP_START: begin
                    // Entered from INIT with the pulse already raised; entered
                    // from STEP_WAIT with it low, so it rises one cycle later.
                    if (o_step_start) begin
                        o_step_start <= 1'b0;
                        state        <= STEP_WAIT;
                    end else begin
                        o_step_start <= 1'b1;
                    end
                end
                STEP_WAIT: begin
                    if (i_step_done) begin
                        if (!iter_match) begin
                            state <= STEP_START;
                        end else if (num_dump != '0) begin
                            state        <= DUMP;
                            o_dump_start <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DUMP: begin
                    if (dump_match) begin
                        o_dump_start <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // First cycle raises o_done, second returns to IDLE.
                    if (!o_done) begin
                        o_done <= 1'b1;
                    end else begin
                        o_done <= 1'b0;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_init_start <= 1'b0;
                    o_dump_start <= 1'b0;
                    o_step_start <= 1'b0;
                    o_busy       <= 1'b0;
                    o_done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_phase_sequencer.sv
// Bench for md_phase_sequencer. Pulses on o_step_start / o_done are matched
// against an expected queue of {o_done, o_step_start, o_iter_cnt} entries
// pushed by the scenario tasks before the cycle that should produce them.
module tb_md_phase_sequencer;

    logic        clk;
    logic        rst;
    logic        i_start, i_abort;
    logic [15:0] i_node_ID;
    logic [15:0] i_num_pos_beats, i_num_iters, i_num_dump_beats;
    logic        i_h2k_tvalid, i_h2k_tlast, i_k2pc_tvalid, i_k2h_tvalid, i_step_done;
    logic        o_init_start, o_dump_start, o_step_start, o_busy, o_done;
    logic [15:0] o_init_ID, o_iter_cnt;
    logic [2:0]  o_phase;

    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_got, mon_exp;

    md_phase_sequencer #(.CNT_WIDTH(16), .ITER_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_node_ID(i_node_ID), .i_num_pos_beats(i_num_pos_beats),
        .i_num_iters(i_num_iters), .i_num_dump_beats(i_num_dump_beats),
        .i_h2k_tvalid(i_h2k_tvalid), .i_h2k_tlast(i_h2k_tlast),
        .i_k2pc_tvalid(i_k2pc_tvalid), .i_k2h_tvalid(i_k2h_tvalid),
        .i_step_done(i_step_done), .o_init_start(o_init_start),
        .o_dump_start(o_dump_start), .o_init_ID(o_init_ID),
        .o_step_start(o_step_start), .o_phase(o_phase),
        .o_iter_cnt(o_iter_cnt), .o_busy(o_busy), .o_done(o_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (o_step_start || o_done) begin
            mon_got = {o_done, o_step_start, o_iter_cnt};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected got=%h expected=none t=%0t", mon_got, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL pulse_event got=%h expected=%h t=%0t", mon_got, mon_exp, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_start = 0; i_abort = 0; i_h2k_tvalid = 0; i_h2k_tlast = 0;
        i_k2pc_tvalid = 0; i_k2h_tvalid = 0; i_step_done = 0;
    endtask

    task automatic start_run(input logic [15:0] node, input logic [15:0] pos,
                             input logic [15:0] iters, input logic [15:0] dump);
        i_node_ID = node; i_num_pos_beats = pos; i_num_iters = iters; i_num_dump_beats = dump;
        i_start = 1;
        tick();
        i_start = 0;
        n_vec++; if (o_phase !== 3'd1) begin n_err++; $display("FAIL start_phase got=%0d expected=1", o_phase); end
        n_vec++; if (o_init_start !== 1'b1 || o_busy !== 1'b1) begin n_err++; $display("FAIL start_enables got=%b%b expected=11", o_init_start, o_busy); end
        n_vec++; if (o_init_ID !== node) begin n_err++; $display("FAIL start_init_id got=%h expected=%h", o_init_ID, node); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        i_node_ID = 16'h0; i_num_pos_beats = 0; i_num_iters = 0; i_num_dump_beats = 0;
        rst = 1;
        repeat (3) tick();
        n_vec++; if ({o_init_start, o_dump_start, o_step_start, o_busy, o_done} !== 5'b0) begin n_err++; $display("FAIL reset_flags got=%b expected=00000", {o_init_start, o_dump_start, o_step_start, o_busy, o_done}); end
        n_vec++; if (o_phase !== 3'd0) begin n_err++; $display("FAIL reset_phase got=%0d expected=0", o_phase); end
        n_vec++; if (o_iter_cnt !== 16'd0 || o_init_ID !== 16'd0) begin n_err++; $display("FAIL reset_values got=%h/%h expected=0/0", o_iter_cnt, o_init_ID); end
        rst = 0;
        for (int c = 0; c < 8; c++) begin
            i_step_done  = 1'($urandom_range(0, 1));
            i_k2h_tvalid = 1'($urandom_range(0, 1));
            tick();
            n_vec++; if (o_phase !== 3'd0 || o_busy !== 1'b0 || o_iter_cnt !== 16'd0) begin n_err++; $display("FAIL idle_strobes got=%0d/%b/%0d expected=0/0/0", o_phase, o_busy, o_iter_cnt); end
        end
        idle_inputs();
    endtask

    task automatic test_init_exit();
        start_run(16'hA5A5, 16'd8, 16'd3, 16'd4);
        for (int s = 0; s < 8; s++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                n_vec++; if (o_init_start !== 1'b1) begin n_err++; $display("FAIL init_gap got=%b expected=1", o_init_start); end
            end
            i_k2pc_tvalid = 1;
            i_h2k_tvalid  = (s < 5);
            i_h2k_tlast   = (s == 4);
            if (s == 7) exp_q.push_back({1'b0, 1'b1, 16'd0});
            tick();
            idle_inputs();
            if (s < 7) begin
                n_vec++; if (o_init_start !== 1'b1 || o_phase !== 3'd1) begin n_err++; $display("FAIL init_hold beat=%0d got=%b/%0d expected=1/1", s, o_init_start, o_phase); end
            end
        end
        n_vec++; if (o_init_start !== 1'b0) begin n_err++; $display("FAIL init_exit_enable got=%b expected=0", o_init_start); end
        n_vec++; if (o_phase !== 3'd2 || o_step_start !== 1'b1) begin n_err++; $display("FAIL init_exit_step got=%0d/%b expected=2/1", o_phase, o_step_start); end
    endtask

    task automatic test_steps();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 10; c++) begin
                tick();
                n_vec++; if (o_phase !== 3'd3 || o_step_start !== 1'b0) begin n_err++; $display("FAIL step_wait iter=%0d got=%0d/%b expected=3/0", k, o_phase, o_step_start); end
            end
            i_step_done = 1;
            tick();
            i_step_done = 0;
            n_vec++; if (o_iter_cnt !== 16'(k + 1)) begin n_err++; $display("FAIL iter_cnt got=%0d expected=%0d", o_iter_cnt, k + 1); end
            if (k < 2) begin
                n_vec++; if (o_phase !== 3'd2 || o_step_start !== 1'b0) begin n_err++; $display("FAIL step_gap got=%0d/%b expected=2/0", o_phase, o_step_start); end
                exp_q.push_back({1'b0, 1'b1, 16'(k + 1)});
                tick();
                n_vec++; if (o_step_start !== 1'b1) begin n_err++; $display("FAIL step_pulse got=%b expected=1", o_step_start); end
            end else begin
                n_vec++; if (o_phase !== 3'd4 || o_dump_start !== 1'b1) begin n_err++; $display("FAIL to_dump got=%0d/%b expected=4/1", o_phase, o_dump_start); end
            end
        end
    endtask

    task automatic test_dump();
        for (int s = 0; s < 4; s++) begin
            repeat ($urandom_range(0, 2)) tick();
            i_k2h_tvalid = 1;
            tick();
            i_k2h_tvalid = 0;
            if (s < 3) begin
                n_vec++; if (o_dump_start !== 1'b1) begin n_err++; $display("FAIL dump_hold beat=%0d got=%b expected=1", s, o_dump_start); end
            end
        end
        n_vec++; if (o_dump_start !== 1'b0 || o_phase !== 3'd5 || o_done !== 1'b0) begin n_err++; $display("FAIL dump_exit got=%b/%0d/%b expected=0/5/0", o_dump_start, o_phase, o_done); end
        exp_q.push_back({1'b1, 1'b0, 16'd3});
        tick();
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL done_pulse got=%b expected=1", o_done); end
        tick();
        n_vec++; if (o_phase !== 3'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL done_idle got=%0d/%b/%b expected=0/0/0", o_phase, o_busy, o_done); end
    endtask

    task automatic test_zero_iters();
        start_run(16'h0042, 16'd2, 16'd0, 16'd0);
        i_k2pc_tvalid = 1; i_h2k_tvalid = 1; i_h2k_tlast = 1;
        tick();
        idle_inputs();
        n_vec++; if (o_phase !== 3'd1) begin n_err++; $display("FAIL zero_init_hold got=%0d expected=1", o_phase); end
        i_k2pc_tvalid = 1;
        tick();
        idle_inputs();
        n_vec++; if (o_phase !== 3'd5 || o_init_start !== 1'b0) begin n_err++; $display("FAIL zero_to_done got=%0d/%b expected=5/0", o_phase, o_init_start); end
        exp_q.push_back({1'b1, 1'b0, 16'd0});
        tick();
        n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL zero_done got=%b expected=1", o_done); end
        tick();
        tick();
        n_vec++; if (o_phase !== 3'd0 || o_done !== 1'b0) begin n_err++; $display("FAIL zero_idle got=%0d/%b expected=0/0", o_phase, o_done); end
    endtask

    task automatic test_abort();
        start_run(16'h0777, 16'd1, 16'd1, 16'd16);
        i_k2pc_tvalid = 1; i_h2k_tvalid = 1; i_h2k_tlast = 1;
        exp_q.push_back({1'b0, 1'b1, 16'd0});
        tick();
        idle_inputs();
        tick();
        i_step_done = 1;
        tick();
        i_step_done = 0;
        n_vec++; if (o_phase !== 3'd4) begin n_err++; $display("FAIL abort_in_dump got=%0d expected=4", o_phase); end
        for (int s = 0; s < 4; s++) begin
            i_k2h_tvalid = 1;
            tick();
        end
        i_k2h_tvalid = 0;
        i_abort = 1;
        tick();
        i_abort = 0;
        n_vec++; if (o_phase !== 3'd0 || o_dump_start !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got=%0d/%b/%b expected=0/0/0", o_phase, o_dump_start, o_busy); end
        n_vec++; if (o_iter_cnt !== 16'd1 || o_init_ID !== 16'h0777) begin n_err++; $display("FAIL abort_held got=%0d/%h expected=1/0777", o_iter_cnt, o_init_ID); end
        for (int c = 0; c < 5; c++) begin
            i_k2h_tvalid = 1;
            tick();
        end
        i_k2h_tvalid = 0;
        n_vec++; if (o_phase !== 3'd0) begin n_err++; $display("FAIL abort_stays got=%0d expected=0", o_phase); end
    endtask

    task automatic test_busy_start();
        start_run(16'h1234, 16'd3, 16'd0, 16'd0);
        i_node_ID = 16'hBEEF; i_num_pos_beats = 16'd1; i_num_iters = 16'd5; i_num_dump_beats = 16'd9;
        i_start = 1;
        for (int s = 0; s < 3; s++) begin
            i_k2pc_tvalid = 1; i_h2k_tvalid = (s == 0); i_h2k_tlast = (s == 0);
            tick();
            if (s < 2) begin
                n_vec++; if (o_phase !== 3'd1 || o_init_ID !== 16'h1234) begin n_err++; $display("FAIL busy_start_ignored got=%0d/%h expected=1/1234", o_phase, o_init_ID); end
            end
        end
        idle_inputs();
        n_vec++; if (o_phase !== 3'd5) begin n_err++; $display("FAIL busy_latched_cfg got=%0d expected=5", o_phase); end
        exp_q.push_back({1'b1, 1'b0, 16'd0});
        tick();
        tick();
        n_vec++; if (o_phase !== 3'd0 || o_init_ID !== 16'h1234) begin n_err++; $display("FAIL busy_end got=%0d/%h expected=0/1234", o_phase, o_init_ID); end
    endtask

    task automatic test_reset_mid_run();
        start_run(16'h0F0F, 16'd4, 16'd2, 16'd2);
        i_k2pc_tvalid = 1;
        tick();
        i_k2pc_tvalid = 0;
        rst = 1;
        tick();
        rst = 0;
        n_vec++; if (o_phase !== 3'd0 || o_busy !== 1'b0 || o_init_start !== 1'b0 || o_init_ID !== 16'd0) begin n_err++; $display("FAIL reset_mid got=%0d/%b/%b/%h expected=0/0/0/0000", o_phase, o_busy, o_init_start, o_init_ID); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_init_exit();
        test_steps();
        test_dump();
        test_zero_iters();
        test_abort();
        test_busy_start();
        test_reset_mid_run();
        repeat (2) tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pulses_missing got=%0d expected=0 pending", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_phase_sequencer.md
# md_phase_sequencer

Top-level phase controller for one MD node kernel. It drives `init_start`, `dump_start` and `init_ID` into the AXIS init/dump dispatcher, and counts the beats that actually pass through it. It sequences the run as: position initialisation from host and network, then N force/motion iterations handshaked with the compute pipeline, then force dump to host. It sits between the host control registers and the dispatcher/compute cluster.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of all beat counters and configured counts.
- `ITER_WIDTH`, default 16: width of the iteration count and iteration counter.

Ports. Reset `rst` is synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `i_start`  in  1  run request; sampled only in IDLE.
- `i_abort`  in  1  abort the run; forces IDLE from any state.
- `i_node_ID`  in  16  this node's ID; latched at start.
- `i_num_pos_beats`  in  CNT_WIDTH  position beats this node's caches must receive (host plus network); latched at start.
- `i_num_iters`  in  ITER_WIDTH  iterations to run; latched at start.
- `i_num_dump_beats`  in  CNT_WIDTH  force beats to forward to host; latched at start.
- `i_h2k_tvalid`, `i_h2k_tlast`  in  1 each  host stream monitor (same signals the dispatcher sees).
- `i_k2pc_tvalid`  in  1  dispatcher write strobe to the position caches.
- `i_k2h_tvalid`  in  1  dispatcher write strobe to the host.
- `i_step_done`  in  1  one-cycle pulse from compute at the end of an iteration.
- `o_init_start`  out  1  dispatcher init enable.
- `o_dump_start`  out  1  dispatcher dump enable.
- `o_init_ID`  out  16  latched node ID.
- `o_step_start`  out  1  one-cycle pulse that starts an iteration.
- `o_phase`  out  3  current state encoding (`md_phase_t`).
- `o_iter_cnt`  out  ITER_WIDTH  completed iterations.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.
- `o_done`  out  1  one-cycle completion pulse.

## Operation
States: IDLE, INIT, STEP_START, STEP_WAIT, DUMP, DONE.
- **IDLE:** on `i_start`, latch all config inputs, clear all counters, go to INIT.
- **INIT:** `o_init_start`=1.
  - `pos_cnt` increments on each `i_k2pc_tvalid`.
  - `host_fin` sets on `i_h2k_tvalid & i_h2k_tlast`.
  - Exit when `host_fin` (including a set in the current cycle) and `pos_cnt_next == num_pos_beats`.
  - Exit target is STEP_START if `num_iters != 0`, else DUMP, or DONE if `num_dump_beats == 0` as well.
- **STEP_START:** `o_step_start`=1 for exactly one cycle, then go to STEP_WAIT.
- **STEP_WAIT:** on `i_step_done`, `iter_cnt++`.
  - If `iter_cnt+1 == num_iters`, go to DUMP, or DONE if `num_dump_beats == 0`.
  - Otherwise go to STEP_START.
  - An `i_step_done` seen in any other state is ignored.
- **DUMP:** `o_dump_start`=1. `dump_cnt` increments on `i_k2h_tvalid`. Exit to DONE when `dump_cnt_next == num_dump_beats`.
- **DONE:** `o_done`=1 for one cycle, then go to IDLE.
- **Abort:** `i_abort` has priority over every transition. The next state is IDLE with all outputs deasserted. Counters and config are held, not cleared.
- **Counter widths:** counters saturate at all-ones and never wrap. Strobes arriving after the exit condition is met are not counted.

## Timing
- All outputs are registered.
- Reset values: every output is 0 (`o_phase` = IDLE), all counters are 0, all latched config is 0.
- `i_start` at cycle t gives `o_init_start`=1 and `o_busy`=1 from t+1.
- Exit condition met at cycle t gives `o_init_start`=0 at t+1. `o_step_start` also asserts at t+1 when the next state is STEP_START.
- `i_step_done` at t (not the last iteration) gives `o_step_start` at t+2.
- Last DUMP strobe at t gives `o_dump_start`=0 at t+1, `o_done`=1 at t+2, and IDLE at t+3.
- `i_start` is ignored while busy.
- Reset asserted mid-run returns to IDLE in the next cycle.
- There is no backpressure: counting is on valid strobes only.

## Structure
- `MD_pkg` holds the `md_phase_t` enum (IDLE=0, INIT=1, STEP_START=2, STEP_WAIT=3, DUMP=4, DONE=5) and the `CNT_WIDTH`/`ITER_WIDTH` defaults.
- Sub-module `sat_beat_counter`, instantiated three times: a saturating counter with clear, increment enable and a `next == target` compare output.
- The FSM stays in this module.

## Test plan
- Reset, then idle → all outputs 0; `i_step_done`/`i_k2h_tvalid` strobes have no effect.
- `num_pos`=8, 8 `k2pc` strobes, tlast on the 5th host beat → `o_init_start` high until the cycle after the 8th strobe.
- `num_iters`=3, `i_step_done` 10 cycles after each `o_step_start` → 3 step pulses, `o_iter_cnt`=3, then DUMP.
- `num_iters`=0, `num_dump`=0 → INIT goes directly to DONE; single `o_done` pulse.
- `i_abort` mid-DUMP with `dump_cnt`=4 of 16 → IDLE next cycle, `o_dump_start`=0, no `o_done`.
- `i_start` while busy → ignored; the latched config is unchanged.
